// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: execution controller for the pipelined MIPS core.
// Converts a debounced push-button and a run/step switch into a single-cycle
// clock-enable for the processor. Supports single-step, free-run (one enable
// every RUN_DIV cycles) and breakpoint-stopped free-run, plus a latched fault
// halt and a count of enabled cycles for the display.
//
// Ports:
//   clk        - board clock, all logic on posedge
//   rst        - synchronous active-high reset
//   btn        - debounced push-button level, synchronous to clk
//   mode_run   - 1 = free-run, 0 = single-step
//   bp_en      - breakpoint enable
//   bp_addr    - breakpoint PC
//   pc_current - processor PC
//   halt_req   - fault request (level)
//   cpu_en     - processor clock-enable
//   state      - IDLE=0, STEP=1, RUN=2, BREAK=3, FAULT=4
//   cycle_cnt  - number of cycles with cpu_en asserted (wraps)
//   at_break   - high while in BREAK
module mips_run_ctrl #(
    parameter int unsigned RUN_DIV = 50000,
    parameter int unsigned DIV_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic        mode_run,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_current,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic [2:0]  state,
    output logic [15:0] cycle_cnt,
    output logic        at_break
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStep  = 3'd1,
        StRun   = 3'd2,
        StBreak = 3'd3,
        StFault = 3'd4
    } state_e;

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(RUN_DIV - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             skip_q;
    logic             skip_set;
    logic             btn_q;
    logic [15:0]      cycle_cnt_q;

    logic btn_edge;
    logic bp_hit;
    logic tick;

    assign btn_edge = btn & ~btn_q;
    assign bp_hit   = bp_en & (pc_current == bp_addr) & ~skip_q;
    assign tick     = (div_q == DivLast);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; halt_req outranks everything but reset
    always_comb begin
        state_d  = state_q;
        skip_set = 1'b0;
        if (halt_req) begin
            state_d = StFault;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (btn_edge) begin
                        state_d = mode_run ? StRun : StStep;
                    end
                end
                StStep: begin
                    state_d = StIdle;
                end
                StRun: begin
                    if (bp_hit) begin
                        state_d = StBreak;
                    end else if (btn_edge || !mode_run) begin
                        state_d = StIdle;
                    end
                end
                StBreak: begin
                    // Leaving a breakpoint arms skip so the same PC does not re-trigger
                    if (btn_edge) begin
                        state_d  = mode_run ? StRun : StStep;
                        skip_set = 1'b1;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Output decode; a fault request or reset suppresses any enable this cycle
    always_comb begin
        cpu_en   = 1'b0;
        at_break = 1'b0;
        unique case (state_q)
            StStep:  cpu_en = 1'b1;
            StRun:   cpu_en = tick & ~bp_hit;
            StBreak: at_break = 1'b1;
            default: begin
                cpu_en   = 1'b0;
                at_break = 1'b0;
            end
        endcase
        cpu_en = cpu_en & ~halt_req & ~rst;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        // btn_q follows btn even in reset so a button held across reset is not a press
        btn_q <= btn;
        if (rst) begin
            div_q       <= '0;
            skip_q      <= 1'b0;
            cycle_cnt_q <= 16'd0;
        end else begin
            if (state_d == StRun && state_q != StRun) begin
                div_q <= '0;
            end else if (state_q == StRun && !bp_hit) begin
                div_q <= tick ? '0 : div_q + DIV_W'(1);
            end

            if (skip_set) begin
                skip_q <= 1'b1;
            end else if (cpu_en) begin
                skip_q <= 1'b0;
            end

            if (cpu_en) begin
                cycle_cnt_q <= cycle_cnt_q + 16'd1;
            end
        end
    end

    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
